ctc_multi: RTL and testbench
============================

CTC_MULTI -- requirements
Module: ctc_multi

Interface
REQ-001 Parameter NCH, default 4: number of counter/timer channels, range 1..4.
REQ-002 Parameter CWID, default 8: down-counter and time-constant width, range 8..16.
REQ-003 Parameter DWID, default 8: CPU data bus width.
REQ-004 clk  input  1  single clock; all logic SHALL be rising-edge clk.
REQ-005 reset_n  input  1  reset, synchronous, active-low.
REQ-006 ce_n  input  1  chip enable, active-low.
REQ-007 cs  input  2  channel select; values >= NCH SHALL be ignored.
REQ-008 m1_n, rd_n, iorq_n  input  1 each  Z80 bus strobes, active-low.
REQ-009 din  input  DWID  write data; dout  output  DWID  read data.
REQ-010 oe_n  output  1  dout valid, active-low.
REQ-011 iei  input  1  daisy-chain enable in; ieo  output  1  daisy-chain enable out.
REQ-012 int_n  output  1  interrupt request, active-low.
REQ-013 clk_trg  input  NCH  per-channel external clock/trigger, bit i for channel i.
REQ-014 zc_to  output  NCH  per-channel zero-count pulse.

Function
REQ-015 Write strobe SHALL fire for exactly one clk on the first cycle of (!ce_n && !iorq_n && rd_n && m1_n); read strobe on the first cycle of (!ce_n && !iorq_n && !rd_n && m1_n); acknowledge strobe on the first cycle of (!ce_n && !iorq_n && !m1_n).
REQ-016 Write to channel cs with the channel's tc_follow flag set SHALL load the time constant from din[CWID-1:0] (DWID < CWID: two writes, low byte then high byte) and clear tc_follow.
REQ-017 Otherwise, din[0]=1 SHALL load the channel control word (CCW) and set tc_follow = din[2]; din[0]=0 written to channel 0 SHALL load vector bits [7:3]; elsewhere it is ignored.
REQ-018 CCW bits: 1 sw-reset, 3 external trigger start, 4 rising edge, 5 prescale 256 (else 16), 6 counter mode, 7 interrupt enable.
REQ-019 Per-channel states: IDLE, WAIT_TC, WAIT_TRIG, RUN; sw-reset=1 SHALL force IDLE and hold the counter and prescaler at 0.
REQ-020 IDLE -> WAIT_TC on CCW with sw-reset=0 and tc_follow=1; IDLE -> RUN on CCW with sw-reset=0 when a time constant is already loaded.
REQ-021 WAIT_TC -> RUN after the time constant loads (counter mode, or timer mode with bit3=0); WAIT_TC -> WAIT_TRIG when timer mode with bit3=1.
REQ-022 WAIT_TRIG -> RUN on the selected clk_trg edge; clk_trg SHALL be registered (two-flop sync), with edge detection on the synchronised value.
REQ-023 On entry to RUN the counter SHALL load the time constant; TC value 0 means 2^CWID.
REQ-024 Timer mode: the prescaler SHALL decrement every clk with period 16 or 256; the counter SHALL decrement once per period.
REQ-025 Counter mode: the counter SHALL decrement once per selected clk_trg edge.
REQ-026 On a 1 -> 0 decrement the counter SHALL reload the time constant in the same cycle, and zc_to[i] SHALL be high for exactly the next clk.
REQ-027 A time-constant write while in RUN SHALL update the reload value only; the running count SHALL NOT change.
REQ-028 Read SHALL return the current counter of channel cs on dout (zero-extended, low DWID bits) with oe_n=0 for one clk after the strobe; dout=0 and oe_n=1 otherwise.
REQ-029 A zero crossing with CCW bit7=1 SHALL set the channel's pending bit; a clear bit7 SHALL prevent and clear pending.
REQ-030 int_n SHALL be low while iei=1 and any pending or in-service bit is set, and no channel is in service.
REQ-031 The acknowledge strobe with iei=1 SHALL select the lowest-index pending channel, move it from pending to in-service, and drive dout = {vector[7:3], chan[1:0], 1'b0} with oe_n=0 for one clk.
REQ-032 In-service SHALL clear on a write of CCW to that channel or when the RETI opcode sequence (ED 4D) is observed on din during M1 reads.
REQ-033 ieo SHALL be iei && no in-service bit set && (no pending bit set, or an M1 cycle is active).
REQ-034 When two channels cross zero in the same clk, both SHALL go pending; service order SHALL be ascending index.

Reset
REQ-035 reset_n=0 at a clk edge SHALL set: all channels IDLE with tc_follow=0, CCW=0, time constant=0, counter=0, vector=0, pending=0, in-service=0; outputs dout=0, oe_n=1, int_n=1, ieo=iei, zc_to=0. A reset mid-count SHALL abort within one clk.

Verification
REQ-036 Ch0: CCW 0x05, TC 0x04 -> zc_to[0] pulses every 64 clk, first pulse 64±2 clk after the TC write.
REQ-037 Ch1: CCW 0xC5 (counter mode, int enable), vector 0x40, TC 3, three clk_trg falling edges -> int_n=0; acknowledge -> dout=0x42, int_n=1.
REQ-038 Ch0 and ch2 cross zero in the same clk with interrupts enabled -> first acknowledge returns 0x40, second returns 0x44 after RETI.
REQ-039 Running ch3 with TC 10, write TC 2 mid-count -> current period completes at 10; the next period is 2.
REQ-040 Write CCW 0x03 (sw-reset) during RUN -> the counter reads 0 within two clk and no zc_to or interrupt follows.

Source files
------------

// File: rtl/ctc_multi.sv
`default_nettype none
// ============================================================================
//  Module      : ctc_multi
//  Description : Multi-channel Z80-style counter/timer with per-channel
//                time constants, prescaled timer and external-trigger counter
//                modes, zero-count pulses and a daisy-chained vectored
//                interrupt controller (ack, in-service, RETI snooping).
//  Revision    : 1.0  initial release
// ============================================================================
module ctc_multi #(
    parameter int NCH  = 4,
    parameter int CWID = 8,
    parameter int DWID = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            ce_n,
    input  logic [1:0]      cs,
    input  logic            m1_n,
    input  logic            rd_n,
    input  logic            iorq_n,
    input  logic [DWID-1:0] din,
    output logic [DWID-1:0] dout,
    output logic            oe_n,
    input  logic            iei,
    output logic            ieo,
    output logic            int_n,
    input  logic [NCH-1:0]  clk_trg,
    output logic [NCH-1:0]  zc_to
);
    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_TC   = 2'd1,
        S_WAIT_TRIG = 2'd2,
        S_RUN       = 2'd3
    } ch_state_t;

    localparam logic [2:0] c_NCH   = 3'(NCH);
    localparam logic [7:0] c_OP_ED = 8'hED;
    localparam logic [7:0] c_OP_4D = 8'h4D;

    // ---------------- bus strobes ----------------
    logic w_wr_cond, w_rd_cond, w_ack_cond, w_m1rd_cond;
    logic r_wr_prev, r_rd_prev, r_ack_prev, r_m1rd_prev;
    logic w_wr_stb, w_rd_stb, w_ack_stb, w_m1rd_stb;
    logic w_cs_ok;

    assign w_wr_cond   = !ce_n && !iorq_n &&  rd_n &&  m1_n;
    assign w_rd_cond   = !ce_n && !iorq_n && !rd_n &&  m1_n;
    assign w_ack_cond  = !ce_n && !iorq_n && !m1_n;
    assign w_m1rd_cond = !m1_n && !rd_n && iorq_n;      // opcode fetch, snooped for RETI
    assign w_wr_stb    = w_wr_cond   && !r_wr_prev;
    assign w_rd_stb    = w_rd_cond   && !r_rd_prev;
    assign w_ack_stb   = w_ack_cond  && !r_ack_prev;
    assign w_m1rd_stb  = w_m1rd_cond && !r_m1rd_prev;
    assign w_cs_ok     = ({1'b0, cs} < c_NCH);

    // Remember last-cycle bus conditions so each strobe fires only on the first cycle
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_prev   <= 1'b0;
            r_rd_prev   <= 1'b0;
            r_ack_prev  <= 1'b0;
            r_m1rd_prev <= 1'b0;
        end else begin
            r_wr_prev   <= w_wr_cond;
            r_rd_prev   <= w_rd_cond;
            r_ack_prev  <= w_ack_cond;
            r_m1rd_prev <= w_m1rd_cond;
        end
    end

    // ---------------- per-channel counter/timers ----------------
    logic [CWID-1:0] w_cnt_all [4];
    logic [NCH-1:0]  w_follow_all, w_ie_all, w_zc_all, w_ccw_wr_all;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        ch_state_t       r_state, w_state_nxt;
        logic [CWID-1:0] r_cnt, w_cnt_nxt;
        logic [CWID-1:0] r_tc, w_tc_nxt;
        logic            r_tcv, w_tcv_nxt;
        logic [7:3]      r_ccw, w_ccw_nxt;
        logic            r_srst, w_srst_nxt;
        logic            r_follow, w_follow_nxt;
        logic [7:0]      r_pre, w_pre_nxt;
        logic            r_zc, w_zc_evt;
        logic [2:0]      r_trg;
        logic            w_sel, w_wr_ccw, w_wr_tc, w_trg_edge, w_tick;
        logic [7:0]      w_pre_top, w_pre_top_new;
        logic [CWID-1:0] w_tc_new;
        logic            w_tc_done;

        assign w_sel         = w_cs_ok && (cs == 2'(i));
        assign w_wr_ccw      = w_wr_stb && w_sel && !r_follow && din[0];
        assign w_wr_tc       = w_wr_stb && w_sel && r_follow;
        // r_trg[1] is the synchronised trigger, r_trg[2] its previous value
        assign w_trg_edge    = r_ccw[4] ? (r_trg[1] && !r_trg[2]) : (!r_trg[1] && r_trg[2]);
        assign w_pre_top     = r_ccw[5] ? 8'd255 : 8'd15;
        assign w_pre_top_new = din[5]   ? 8'd255 : 8'd15;
        assign w_tick        = r_ccw[6] ? w_trg_edge : (r_pre == 8'd0);

        if (DWID >= CWID) begin : g_tc_one
            assign w_tc_new  = din[CWID-1:0];
            assign w_tc_done = 1'b1;
        end else begin : g_tc_two
            logic [DWID-1:0] r_tc_lo;
            logic            r_tc_hi;
            // Stage the low byte until the high byte completes the constant
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    r_tc_lo <= '0;
                    r_tc_hi <= 1'b0;
                end else if (w_wr_ccw) begin
                    r_tc_hi <= 1'b0;
                end else if (w_wr_tc) begin
                    if (!r_tc_hi) r_tc_lo <= din;
                    r_tc_hi <= !r_tc_hi;
                end
            end
            assign w_tc_new  = {din[CWID-DWID-1:0], r_tc_lo};
            assign w_tc_done = r_tc_hi;
        end

        // Channel next-state: run/trigger progress first, then CPU writes override
        always_comb begin
            w_state_nxt  = r_state;
            w_cnt_nxt    = r_cnt;
            w_pre_nxt    = r_pre;
            w_tc_nxt     = r_tc;
            w_tcv_nxt    = r_tcv;
            w_ccw_nxt    = r_ccw;
            w_srst_nxt   = r_srst;
            w_follow_nxt = r_follow;
            w_zc_evt     = 1'b0;
            case (r_state)
                S_WAIT_TRIG: begin
                    if (w_trg_edge) begin
                        w_state_nxt = S_RUN;
                        w_cnt_nxt   = r_tc;
                        w_pre_nxt   = w_pre_top;
                    end
                end
                S_RUN: begin
                    if (!r_ccw[6]) w_pre_nxt = (r_pre == 8'd0) ? w_pre_top : r_pre - 8'd1;
                    if (w_tick) begin
                        // A count of 0 wraps, giving the full 2^CWID period
                        if (r_cnt == CWID'(1)) begin
                            w_cnt_nxt = r_tc;
                            w_zc_evt  = 1'b1;
                        end else begin
                            w_cnt_nxt = r_cnt - CWID'(1);
                        end
                    end
                end
                default: ;
            endcase
            if (r_srst) begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_pre_nxt   = 8'd0;
            end
            if (w_wr_ccw) begin
                w_ccw_nxt    = din[7:3];
                w_srst_nxt   = din[1];
                w_follow_nxt = din[2];
                if (din[1]) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_pre_nxt   = 8'd0;
                    w_zc_evt    = 1'b0;
                end else if (r_state == S_IDLE) begin
                    if (din[2]) begin
                        w_state_nxt = S_WAIT_TC;
                    end else if (r_tcv) begin
                        w_state_nxt = S_RUN;
                        w_cnt_nxt   = r_tc;
                        w_pre_nxt   = w_pre_top_new;
                    end
                end
            end else if (w_wr_tc && w_tc_done) begin
                // While running only the reload value changes
                w_tc_nxt     = w_tc_new;
                w_tcv_nxt    = 1'b1;
                w_follow_nxt = 1'b0;
                if (r_state == S_WAIT_TC) begin
                    if (!r_ccw[6] && r_ccw[3]) begin
                        w_state_nxt = S_WAIT_TRIG;
                    end else begin
                        w_state_nxt = S_RUN;
                        w_cnt_nxt   = w_tc_new;
                        w_pre_nxt   = w_pre_top;
                    end
                end
            end
        end

        // Channel state register and trigger synchroniser
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                r_state  <= S_IDLE;
                r_cnt    <= '0;
                r_pre    <= 8'd0;
                r_tc     <= '0;
                r_tcv    <= 1'b0;
                r_ccw    <= '0;
                r_srst   <= 1'b0;
                r_follow <= 1'b0;
                r_zc     <= 1'b0;
                r_trg    <= 3'b000;
            end else begin
                r_state  <= w_state_nxt;
                r_cnt    <= w_cnt_nxt;
                r_pre    <= w_pre_nxt;
                r_tc     <= w_tc_nxt;
                r_tcv    <= w_tcv_nxt;
                r_ccw    <= w_ccw_nxt;
                r_srst   <= w_srst_nxt;
                r_follow <= w_follow_nxt;
                r_zc     <= w_zc_evt;
                r_trg    <= {r_trg[1:0], clk_trg[i]};
            end
        end

        assign w_cnt_all[i]    = r_cnt;
        assign w_follow_all[i] = r_follow;
        assign w_ie_all[i]     = r_ccw[7];
        assign w_zc_all[i]     = w_zc_evt;
        assign w_ccw_wr_all[i] = w_wr_ccw;
        assign zc_to[i]        = r_zc;
    end

    for (genvar i = NCH; i < 4; i++) begin : g_pad
        assign w_cnt_all[i] = '0;
    end

    // ---------------- interrupt controller ----------------
    logic [7:3]     r_vector;
    logic [NCH-1:0] r_pend, r_ins;
    logic           r_ed_seen;
    logic           w_ack_hit, w_take, w_reti;
    logic [1:0]     w_ack_ch;
    logic [NCH-1:0] w_take_vec, w_ins_low;

    assign w_take = w_ack_stb && iei && w_ack_hit;
    assign w_reti = w_m1rd_stb && r_ed_seen && (din[7:0] == c_OP_4D);
    assign int_n  = !(iei && (|r_pend) && !(|r_ins));
    assign ieo    = iei && !(|r_ins) && (!(|r_pend) || !m1_n);

    // Lowest-index pending channel wins the acknowledge; lowest in-service is retired
    always_comb begin
        w_ack_hit = 1'b0;
        w_ack_ch  = 2'd0;
        w_ins_low = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (r_pend[k]) begin
                w_ack_hit = 1'b1;
                w_ack_ch  = 2'(k);
            end
            if (r_ins[k]) begin
                w_ins_low    = '0;
                w_ins_low[k] = 1'b1;
            end
        end
        for (int k = 0; k < NCH; k++) begin
            w_take_vec[k] = w_take && (w_ack_ch == 2'(k));
        end
    end

    // Vector, pending/in-service bookkeeping and RETI opcode tracking
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_vector  <= '0;
            r_pend    <= '0;
            r_ins     <= '0;
            r_ed_seen <= 1'b0;
        end else begin
            if (w_wr_stb && (cs == 2'd0) && !w_follow_all[0] && !din[0]) r_vector <= din[7:3];
            r_pend <= ((r_pend & ~w_take_vec) | w_zc_all) & w_ie_all;
            r_ins  <= (r_ins | w_take_vec) & ~w_ccw_wr_all & ~(w_reti ? w_ins_low : '0);
            if (w_m1rd_stb) r_ed_seen <= (din[7:0] == c_OP_ED);
        end
    end

    // Read data and acknowledge vector are presented for one clock after the strobe
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dout <= '0;
            oe_n <= 1'b1;
        end else begin
            dout <= '0;
            oe_n <= 1'b1;
            if (w_rd_stb && w_cs_ok) begin
                dout <= DWID'(w_cnt_all[cs]);
                oe_n <= 1'b0;
            end else if (w_take) begin
                dout <= DWID'({r_vector, w_ack_ch, 1'b0});
                oe_n <= 1'b0;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_ctc_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ctc_multi
//  Description : Directed scoreboard bench for ctc_multi: reads and
//                acknowledges queue their expected bytes, a monitor pops and
//                compares whenever oe_n is low; level/timing checks inline.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ctc_multi;
    localparam int NCH  = 4;
    localparam int CWID = 8;
    localparam int DWID = 8;

    logic            clk     = 1'b0;
    logic            reset_n = 1'b0;
    logic            ce_n    = 1'b1;
    logic [1:0]      cs      = 2'd0;
    logic            m1_n    = 1'b1;
    logic            rd_n    = 1'b1;
    logic            iorq_n  = 1'b1;
    logic [DWID-1:0] din     = '0;
    logic [DWID-1:0] dout;
    logic            oe_n;
    logic            iei     = 1'b1;
    logic            ieo;
    logic            int_n;
    logic [NCH-1:0]  clk_trg = '1;
    logic [NCH-1:0]  zc_to;

    int              n_vec = 0;
    int              n_err = 0;
    logic [7:0]      exp_q [$];
    int              zc_cnt [4];
    time             t_stb;

    ctc_multi #(.NCH(NCH), .CWID(CWID), .DWID(DWID)) dut (
        .clk(clk), .reset_n(reset_n), .ce_n(ce_n), .cs(cs),
        .m1_n(m1_n), .rd_n(rd_n), .iorq_n(iorq_n),
        .din(din), .dout(dout), .oe_n(oe_n),
        .iei(iei), .ieo(ieo), .int_n(int_n),
        .clk_trg(clk_trg), .zc_to(zc_to)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every presented byte must match the oldest expectation
    always @(negedge clk) begin
        logic [7:0] e;
        if (oe_n === 1'b0) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL dout_unexpected: got 0x%02h, required no output", dout);
            end else begin
                e = exp_q.pop_front();
                if (dout !== e) begin
                    n_err++;
                    $display("FAIL dout: got 0x%02h, required 0x%02h", dout, e);
                end
            end
        end
        for (int k = 0; k < NCH; k++) if (zc_to[k] === 1'b1) zc_cnt[k]++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic bus_cycle(input logic [1:0] ch, input logic [7:0] d, input logic m1, input logic rd);
        @(posedge clk); #1;
        cs = ch; din = d; ce_n = 1'b0; iorq_n = 1'b0; m1_n = m1; rd_n = rd;
        @(posedge clk);
        t_stb = $time;
        @(posedge clk); #1;
        ce_n = 1'b1; iorq_n = 1'b1; m1_n = 1'b1; rd_n = 1'b1;
    endtask

    task automatic wr(input logic [1:0] ch, input logic [7:0] d);
        bus_cycle(ch, d, 1'b1, 1'b1);
    endtask

    task automatic rd(input logic [1:0] ch, input logic [7:0] e);
        exp_q.push_back(e);
        bus_cycle(ch, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic ack(input logic [7:0] e);
        exp_q.push_back(e);
        bus_cycle(2'd0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic fetch(input logic [7:0] op);
        @(posedge clk); #1;
        din = op; m1_n = 1'b0; rd_n = 1'b0; ce_n = 1'b1; iorq_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        m1_n = 1'b1; rd_n = 1'b1;
    endtask

    task automatic fall(input logic [3:0] mask);
        @(posedge clk); #1;
        clk_trg = clk_trg & ~mask;
        repeat (3) @(posedge clk);
        #1;
        clk_trg = clk_trg | mask;
        repeat (3) @(posedge clk);
    endtask

    task automatic wait_zc(input int ch, input int budget, output logic found, output time t);
        found = 1'b0;
        t     = 0;
        for (int k = 0; k < budget && !found; k++) begin
            @(negedge clk);
            if (zc_to[ch] === 1'b1) begin
                found = 1'b1;
                t     = $time;
            end
        end
    endtask

    initial begin
        logic f;
        time  t0, t1, t2;
        int   lat, per, z0, z3, zsum;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_dout",  32'(dout),  32'h0);
        check("rst_oe_n",  32'(oe_n),  32'h1);
        check("rst_int_n", 32'(int_n), 32'h1);
        check("rst_ieo",   32'(ieo),   32'h1);
        check("rst_zc_to", 32'(zc_to), 32'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        rd(2'd0, 8'h00);

        // ---- ch0 timer, prescale 16, TC 4: 64-clock zero-count period ----
        wr(2'd0, 8'h05);
        wr(2'd0, 8'h04);
        t0 = t_stb;
        wait_zc(0, 200, f, t1);
        lat = f ? int'((t1 - t0) / 10) : -1;
        n_vec++;
        if (!(lat >= 62 && lat <= 66)) begin
            n_err++;
            $display("FAIL zc0_first_latency: got %0d clk, required 64+-2", lat);
        end
        @(negedge clk);
        check("zc0_width", 32'(zc_to[0]), 32'h0);
        wait_zc(0, 200, f, t2);
        per = f ? int'((t2 - t1) / 10) : -1;
        check("zc0_period", 32'(per), 32'd64);

        // ---- sw-reset while running: counter cleared, no further activity ----
        wr(2'd0, 8'h03);
        rd(2'd0, 8'h00);
        z0 = zc_cnt[0];
        repeat (200) @(posedge clk);
        @(negedge clk);
        check("swrst_no_zc", 32'(zc_cnt[0] - z0), 32'h0);
        check("swrst_int_n", 32'(int_n), 32'h1);

        // ---- ch1 counter mode with interrupt, vector 0x40 ----
        wr(2'd0, 8'h40);
        wr(2'd1, 8'hC5);
        wr(2'd1, 8'h03);
        fall(4'b0010);
        rd(2'd1, 8'h02);
        fall(4'b0010);
        @(negedge clk);
        check("ch1_int_n_before", 32'(int_n), 32'h1);
        fall(4'b0010);
        @(negedge clk);
        check("ch1_int_n_pending", 32'(int_n), 32'h0);
        check("ch1_ieo_pending",   32'(ieo),   32'h0);
        rd(2'd1, 8'h03);
        ack(8'h42);
        @(negedge clk);
        check("ch1_int_n_ack", 32'(int_n), 32'h1);
        check("ch1_ieo_ins",   32'(ieo),   32'h0);
        fetch(8'hED);
        fetch(8'h4D);
        @(negedge clk);
        check("ch1_ieo_reti",   32'(ieo),   32'h1);
        check("ch1_int_n_reti", 32'(int_n), 32'h1);

        // ---- ch0 and ch2 cross zero together ----
        wr(2'd0, 8'hC5);
        wr(2'd0, 8'h02);
        wr(2'd2, 8'hC5);
        wr(2'd2, 8'h02);
        fall(4'b0101);
        fall(4'b0101);
        @(negedge clk);
        check("dual_int_n", 32'(int_n), 32'h0);
        iei = 1'b0;
        @(negedge clk);
        check("iei0_int_n", 32'(int_n), 32'h1);
        check("iei0_ieo",   32'(ieo),   32'h0);
        iei = 1'b1;
        ack(8'h40);
        @(negedge clk);
        check("dual_int_n_ins", 32'(int_n), 32'h1);
        fetch(8'hED);
        fetch(8'h4D);
        @(negedge clk);
        check("dual_int_n_second", 32'(int_n), 32'h0);
        ack(8'h44);
        fetch(8'hED);
        fetch(8'h4D);
        @(negedge clk);
        check("dual_int_n_done", 32'(int_n), 32'h1);
        check("dual_ieo_done",   32'(ieo),   32'h1);

        // ---- ch3: reload change mid-count only affects the next period ----
        wr(2'd3, 8'h45);
        wr(2'd3, 8'd10);
        repeat (4) fall(4'b1000);
        rd(2'd3, 8'd6);
        wr(2'd3, 8'h45);
        wr(2'd3, 8'd2);
        rd(2'd3, 8'd6);
        repeat (5) fall(4'b1000);
        rd(2'd3, 8'd1);
        z3 = zc_cnt[3];
        fall(4'b1000);
        check("ch3_zc_first", 32'(zc_cnt[3] - z3), 32'd1);
        rd(2'd3, 8'd2);
        fall(4'b1000);
        rd(2'd3, 8'd1);
        fall(4'b1000);
        check("ch3_zc_second", 32'(zc_cnt[3] - z3), 32'd2);
        rd(2'd3, 8'd2);

        // ---- hardware reset mid-count ----
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(negedge clk);
        check("mid_rst_oe_n",  32'(oe_n),  32'h1);
        check("mid_rst_int_n", 32'(int_n), 32'h1);
        check("mid_rst_zc_to", 32'(zc_to), 32'h0);
        check("mid_rst_ieo",   32'(ieo),   32'h1);
        @(posedge clk); #1;
        reset_n = 1'b1;
        rd(2'd3, 8'h00);
        rd(2'd0, 8'h00);
        zsum = zc_cnt[0] + zc_cnt[1] + zc_cnt[2] + zc_cnt[3];
        repeat (300) @(posedge clk);
        @(negedge clk);
        check("post_rst_no_zc", 32'(zc_cnt[0] + zc_cnt[1] + zc_cnt[2] + zc_cnt[3] - zsum), 32'h0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
